// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, fetch/decode pipeline register and a
// one-entry buffer that parks a fetched word while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_d,
    output logic [31:0] npc_d,
    output logic        valid_d,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StHold, StHalted} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] npc_q;
    logic        valid_q;
    logic        halted_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_npc_q;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;
    assign imemREN  = (state_q == StFetch);
    assign imemaddr = pc_q;
    assign instr_d  = instr_q;
    assign npc_d    = npc_q;
    assign valid_d  = valid_q;
    assign halted   = halted_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StFetch;
            pc_q        <= PC_INIT;
            instr_q     <= 32'h0;
            npc_q       <= 32'h0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_npc_q   <= 32'h0;
        end else if (state_q != StHalted) begin
            if (redirect) begin
                pc_q        <= {redirect_pc[31:2], 2'b00};
                instr_q     <= 32'h0;
                valid_q     <= 1'b0;
                buf_instr_q <= 32'h0;
                buf_npc_q   <= 32'h0;
                state_q     <= StFetch;
            end else if (halt) begin
                instr_q  <= 32'h0;
                valid_q  <= 1'b0;
                halted_q <= 1'b1;
                state_q  <= StHalted;
            end else if (flush) begin
                instr_q     <= 32'h0;
                npc_q       <= 32'h0;
                valid_q     <= 1'b0;
                buf_instr_q <= 32'h0;
                buf_npc_q   <= 32'h0;
                state_q     <= StFetch;
            end else if (state_q == StFetch) begin
                if (stall) begin
                    // Decode outputs hold; a word arriving now is parked.
                    if (ihit) begin
                        buf_instr_q <= imemload;
                        buf_npc_q   <= pc_plus4;
                        state_q     <= StHold;
                    end
                end else if (ihit) begin
                    instr_q <= imemload;
                    npc_q   <= pc_plus4;
                    valid_q <= 1'b1;
                    pc_q    <= pc_plus4;
                end else begin
                    instr_q <= 32'h0;
                    valid_q <= 1'b0;
                end
            end else if (!stall) begin
                instr_q <= buf_instr_q;
                npc_q   <= buf_npc_q;
                valid_q <= 1'b1;
                pc_q    <= buf_npc_q;
                state_q <= StFetch;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected decode words,
// a negedge monitor pops them whenever a new valid instruction is presented.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, flush, redirect, halt;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, valid_d, halted;
    logic [31:0] imemaddr, instr_d, npc_d;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic        stall_at_edge = 1'b0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr_d(instr_d), .npc_d(npc_d),
        .valid_d(valid_d), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Outputs only change to a new instruction on an edge where stall was low.
    always @(posedge CLK) stall_at_edge <= stall;

    always @(negedge CLK) begin
        if (valid_d && !stall_at_edge) begin
            logic [63:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL decode_unexpected: got instr=%h npc=%h, required no valid output",
                         instr_d, npc_d);
            end else begin
                e = exp_q.pop_front();
                if ({instr_d, npc_d} !== e) begin
                    fails++;
                    $display("FAIL decode_word: got instr=%h npc=%h, required instr=%h npc=%h",
                             instr_d, npc_d, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic idle_inputs();
        ihit = 0; stall = 0; flush = 0; redirect = 0; halt = 0;
        imemload = 32'h0; redirect_pc = 32'h0;
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        #3;
        check("rst_imemREN", {31'h0, imemREN}, 32'h1);
        check("rst_imemaddr", imemaddr, 32'h0);
        check("rst_outputs", {instr_d | npc_d}, 32'h0);
        check("rst_valid_halted", {30'h0, valid_d, halted}, 32'h0);
        #9 nRST = 1'b1;

        // Sequential fetch with one-cycle ihit->decode latency.
        ihit = 1; imemload = 32'h2408_0005;
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imemaddr, 32'(i * 4));
            exp_q.push_back({32'h2408_0005, 32'(i * 4 + 4)});
            tick();
        end
        imemload = 32'h1111_1111;
        exp_q.push_back({32'h1111_1111, 32'h10});
        tick();
        ihit = 0;
        tick();
        check("bubble_valid", {31'h0, valid_d}, 32'h0);
        check("bubble_addr", imemaddr, 32'h10);

        // Stall with ihit parks the word in HOLD.
        stall = 1; ihit = 1; imemload = 32'h3C01_1234;
        tick();
        ihit = 0;
        check("hold_imemREN", {31'h0, imemREN}, 32'h0);
        check("hold_addr", imemaddr, 32'h10);
        tick();
        check("hold2_imemREN", {31'h0, imemREN}, 32'h0);
        stall = 0;
        exp_q.push_back({32'h3C01_1234, 32'h14});
        tick();
        check("unhold_addr", imemaddr, 32'h14);
        check("unhold_imemREN", {31'h0, imemREN}, 32'h1);

        // Stall in FETCH without ihit holds decode outputs.
        ihit = 1; imemload = 32'hAAAA_0001;
        exp_q.push_back({32'hAAAA_0001, 32'h18});
        tick();
        ihit = 0; stall = 1;
        tick();
        tick();
        check("stall_hold_instr", instr_d, 32'hAAAA_0001);
        check("stall_hold_valid", {31'h0, valid_d}, 32'h1);
        check("stall_hold_addr", imemaddr, 32'h18);

        // Flush overrides stall and drops the buffered word.
        ihit = 1; imemload = 32'hBBBB_0002;
        tick();
        ihit = 0; flush = 1;
        tick();
        flush = 0; stall = 0;
        check("flush_outputs", instr_d | npc_d, 32'h0);
        check("flush_valid", {31'h0, valid_d}, 32'h0);
        check("flush_imemREN", {31'h0, imemREN}, 32'h1);
        check("flush_addr", imemaddr, 32'h18);

        // Redirect beats a same-cycle ihit and aligns the target.
        redirect = 1; redirect_pc = 32'h0000_0103; ihit = 1; imemload = 32'hDEAD_BEEF;
        tick();
        redirect = 0; ihit = 0;
        check("redir_addr", imemaddr, 32'h100);
        check("redir_valid", {31'h0, valid_d}, 32'h0);

        // PC+4 wraps at the top of the address space.
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0; ihit = 1; imemload = 32'hCAFE_0001;
        exp_q.push_back({32'hCAFE_0001, 32'h0});
        tick();
        ihit = 0;
        check("wrap_addr", imemaddr, 32'h0);

        // Redirect wins over halt; halt alone stops fetch for good.
        redirect = 1; halt = 1; redirect_pc = 32'h200;
        tick();
        redirect = 0; halt = 0;
        check("redir_halt_halted", {31'h0, halted}, 32'h0);
        check("redir_halt_imemREN", {31'h0, imemREN}, 32'h1);
        check("redir_halt_addr", imemaddr, 32'h200);
        halt = 1; ihit = 1; imemload = 32'h1234_5678;
        tick();
        halt = 0;
        check("halt_valid", {31'h0, valid_d}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            redirect = i[0]; redirect_pc = 32'h400; flush = i[1]; stall = i[2];
            tick();
            check("halted_flag", {31'h0, halted}, 32'h1);
            check("halted_imemREN", {31'h0, imemREN}, 32'h0);
            check("halted_addr", imemaddr, 32'h200);
        end
        idle_inputs();

        // Reset out of HALTED, then an asynchronous reset pulse while in HOLD.
        #2 nRST = 1'b0;
        #1;
        check("rst_halted_flag", {31'h0, halted}, 32'h0);
        check("rst_halted_addr", imemaddr, 32'h0);
        nRST = 1'b1;
        tick();
        ihit = 1; imemload = 32'h0000_AAAA;
        exp_q.push_back({32'h0000_AAAA, 32'h4});
        tick();
        stall = 1; imemload = 32'h0000_BBBB;
        tick();
        ihit = 0;
        check("pre_rst_imemREN", {31'h0, imemREN}, 32'h0);
        #2 nRST = 1'b0;
        #1;
        check("async_rst_outputs", instr_d | npc_d, 32'h0);
        check("async_rst_valid", {31'h0, valid_d}, 32'h0);
        check("async_rst_addr", imemaddr, 32'h0);
        check("async_rst_imemREN", {31'h0, imemREN}, 32'h1);
        nRST = 1'b1;
        stall = 0; ihit = 1; imemload = 32'h0000_1234;
        exp_q.push_back({32'h0000_1234, 32'h4});
        tick();
        ihit = 0;
        check("post_rst_addr", imemaddr, 32'h4);
        tick();
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
